vcnpu_run_sequencer: RTL and testbench

//  Synthesisable multi-channel run controller for VCNPU cores: issues one-cycle start pulses, counts cycles until each done, flags timeouts.

---
 rtl/vcnpu_seq_pkg.sv | 27 ++
 rtl/vcnpu_ch_timer.sv | 59 +++++
 rtl/vcnpu_run_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_vcnpu_run_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcnpu_seq_pkg.sv
// Shared definitions for the VCNPU run sequencer: FSM state encoding,
// the default per-run timeout and the error-counter saturation constant.
// Optional feature macro used by the top: VCNPU_SEQ_STATS_EN.
package vcnpu_seq_pkg;

    // Run sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Timeout applied when the host programs timeout_cycles == 0
    localparam int unsigned TIMEOUT_DEFAULT = 2000;

    // Saturation value of a w-bit error counter
    function automatic int unsigned err_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Default error-counter width and its saturation value
    localparam int unsigned ERR_W_DEFAULT = 8;
    localparam int unsigned ERR_MAX       = err_max(ERR_W_DEFAULT);

endpackage

// File: rtl/vcnpu_ch_timer.sv
// Per-channel run timer: counts WAIT cycles, latches done, detects timeout.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   clr_i        clears counter and status (asserted during LAUNCH)
//   en_i         counting enabled (WAIT state and channel enabled)
//   done_i       done from the NPU
//   timeout_i    timeout limit in cycles (never 0)
//   finished_o   channel finished this run (done or timeout)
//   timed_out_o  channel finished by timeout
//   cycles_o     latency of this run; frozen once finished
module vcnpu_ch_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             done_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic             finished_o,
    output logic             timed_out_o,
    output logic [CNT_W-1:0] cycles_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             fin_q;
    logic             tout_q;

    // Count includes the current cycle, so a done in the first WAIT cycle reads 1
    assign cnt_inc_d = cnt_q + CNT_W'(1);

    // Counter with done latch; done wins over a coincident timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            fin_q  <= 1'b0;
            tout_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            fin_q  <= 1'b0;
            tout_q <= 1'b0;
        end else if (en_i && !fin_q) begin
            cnt_q <= cnt_inc_d;
            if (done_i) begin
                fin_q <= 1'b1;
            end else if (cnt_inc_d == timeout_i) begin
                fin_q  <= 1'b1;
                tout_q <= 1'b1;
            end
        end
    end

    assign finished_o  = fin_q;
    assign timed_out_o = tout_q;
    assign cycles_o    = cnt_q;

endmodule

// File: rtl/vcnpu_run_sequencer.sv
// Multi-channel run controller for VCNPU cores. Issues one-cycle start
// pulses, times each channel until done or timeout, repeats for a
// programmable number of runs and reports pass/fail, a saturating error
// count, sticky timeout flags and per-channel latency.
// Optional feature: define VCNPU_SEQ_STATS_EN to track the worst latency
// per channel in max_cycles_o; otherwise max_cycles_o is tied to 0.
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset; aborts any sequence
//   go_i              starts a sequence when idle
//   num_runs_i        runs per sequence, sampled on accepted go
//   ch_mask_i         enabled channels, sampled on accepted go
//   timeout_cycles_i  per-run timeout (0 = TIMEOUT_DEFAULT), sampled on go
//   npu_start_o       one-cycle start pulse per enabled channel
//   npu_done_i        done from each NPU
//   busy_o            high from accepted go until all_done
//   all_done_o        one-cycle pulse at sequence end
//   pass_o            1 iff no timeouts in the sequence (valid with all_done)
//   error_count_o     saturating timeout count for the sequence
//   timeout_flag_o    sticky per-channel timeout flags
//   last_cycles_o     latency of the most recent run, channel i at [i*CNT_W +: CNT_W]
//   max_cycles_o      worst latency in the sequence (stats build only)
module vcnpu_run_sequencer
    import vcnpu_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RUNS_W = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    go_i,
    input  logic [RUNS_W-1:0]       num_runs_i,
    input  logic [NUM_CH-1:0]       ch_mask_i,
    input  logic [CNT_W-1:0]        timeout_cycles_i,
    output logic [NUM_CH-1:0]       npu_start_o,
    input  logic [NUM_CH-1:0]       npu_done_i,
    output logic                    busy_o,
    output logic                    all_done_o,
    output logic                    pass_o,
    output logic [ERR_W-1:0]        error_count_o,
    output logic [NUM_CH-1:0]       timeout_flag_o,
    output logic [NUM_CH*CNT_W-1:0] last_cycles_o,
    output logic [NUM_CH*CNT_W-1:0] max_cycles_o
);

    localparam int unsigned TO_W  = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = ERR_W + TO_W;
    localparam logic [ERR_W-1:0] ERR_SAT = ERR_W'(err_max(ERR_W));

    seq_state_e               state_q;
    logic [RUNS_W-1:0]        runs_q;
    logic [NUM_CH-1:0]        mask_q;
    logic [CNT_W-1:0]         tmo_q;
    logic [NUM_CH-1:0]        npu_start_q;
    logic                     busy_q;
    logic                     all_done_q;
    logic                     pass_q;
    logic [ERR_W-1:0]         err_q;
    logic [NUM_CH-1:0]        tflag_q;
    logic [NUM_CH*CNT_W-1:0]  last_q;

    logic [NUM_CH-1:0]        fin_w;
    logic [NUM_CH-1:0]        tout_w;
    logic [NUM_CH*CNT_W-1:0]  cyc_w;

    logic                     go_acc_d;
    logic                     all_fin_d;
    logic [TO_W-1:0]          n_tout_d;
    logic [SUM_W-1:0]         err_sum_d;
    logic [ERR_W-1:0]         err_next_d;
    logic [CNT_W-1:0]         tmo_sel_d;

    // Per-channel timers
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vcnpu_ch_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clr_i       (state_q == ST_LAUNCH),
            .en_i        ((state_q == ST_WAIT) && mask_q[g]),
            .done_i      (npu_done_i[g]),
            .timeout_i   (tmo_q),
            .finished_o  (fin_w[g]),
            .timed_out_o (tout_w[g]),
            .cycles_o    (cyc_w[g*CNT_W +: CNT_W])
        );
    end

    // Run bookkeeping: go acceptance, completion and saturating error sum
    always_comb begin
        go_acc_d  = (state_q == ST_IDLE) && go_i;
        all_fin_d = ((fin_w & mask_q) == mask_q);
        tmo_sel_d = (timeout_cycles_i == '0) ? CNT_W'(TIMEOUT_DEFAULT) : timeout_cycles_i;
        n_tout_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_tout_d = n_tout_d + TO_W'(tout_w[i] & mask_q[i]);
        end
        err_sum_d  = SUM_W'(err_q) + SUM_W'(n_tout_d);
        err_next_d = (err_sum_d > SUM_W'(ERR_SAT)) ? ERR_SAT : ERR_W'(err_sum_d);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            runs_q      <= '0;
            mask_q      <= '0;
            tmo_q       <= '0;
            npu_start_q <= '0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            tflag_q     <= '0;
            last_q      <= '0;
        end else begin
            npu_start_q <= '0;
            all_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go_acc_d) begin
                        runs_q  <= num_runs_i;
                        mask_q  <= ch_mask_i;
                        tmo_q   <= tmo_sel_d;
                        err_q   <= '0;
                        tflag_q <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        // Nothing to run: report success without launching
                        if ((num_runs_i == '0) || (ch_mask_i == '0)) begin
                            state_q <= ST_FINISH;
                        end else begin
                            state_q     <= ST_LAUNCH;
                            npu_start_q <= ch_mask_i;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (all_fin_d) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_q   <= err_next_d;
                    tflag_q <= tflag_q | (tout_w & mask_q);
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (mask_q[i]) begin
                            last_q[i*CNT_W +: CNT_W] <= cyc_w[i*CNT_W +: CNT_W];
                        end
                    end
                    runs_q <= runs_q - RUNS_W'(1);
                    if (runs_q == RUNS_W'(1)) begin
                        state_q <= ST_FINISH;
                    end else begin
                        state_q     <= ST_LAUNCH;
                        npu_start_q <= mask_q;
                    end
                end
                ST_FINISH: begin
                    all_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    pass_q     <= (err_q == '0);
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VCNPU_SEQ_STATS_EN
    logic [NUM_CH*CNT_W-1:0] max_q;

    // Worst-case latency per channel, folded in once per run
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
        end else if (go_acc_d) begin
            max_q <= '0;
        end else if (state_q == ST_CHECK) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mask_q[i] && (cyc_w[i*CNT_W +: CNT_W] > max_q[i*CNT_W +: CNT_W])) begin
                    max_q[i*CNT_W +: CNT_W] <= cyc_w[i*CNT_W +: CNT_W];
                end
            end
        end
    end

    assign max_cycles_o = max_q;
`else
    assign max_cycles_o = '0;
`endif

    assign npu_start_o    = npu_start_q;
    assign busy_o         = busy_q;
    assign all_done_o     = all_done_q;
    assign pass_o         = pass_q;
    assign error_count_o  = err_q;
    assign timeout_flag_o = tflag_q;
    assign last_cycles_o  = last_q;

endmodule

// File: tb/tb_vcnpu_run_sequencer.sv
// Self-checking bench for vcnpu_run_sequencer: NPU model with programmable
// per-run latencies, expected results queued at go and popped at all_done.
module tb_vcnpu_run_sequencer;

`ifdef VCNPU_SEQ_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic        pass;
        logic [7:0]  err;
        logic [3:0]  tflag;
        logic [63:0] last;
        logic [63:0] maxc;
        logic [3:0]  starts;   // expected start pulses per enabled channel (same for all)
        logic [3:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  num_runs = '0;
    logic [3:0]  ch_mask = '0;
    logic [15:0] tmo = '0;
    logic [3:0]  npu_start;
    logic [3:0]  npu_done = '0;
    logic        busy, all_done, pass;
    logic [7:0]  err;
    logic [3:0]  tflag;
    logic [63:0] last, maxc;

    logic        go6 = 1'b0;
    logic [7:0]  runs6 = '0;
    logic [0:0]  mask6 = 1'b1;
    logic [15:0] tmo6 = '0;
    logic [0:0]  done6 = 1'b0;
    logic [0:0]  start6;
    logic        busy6, all_done6, pass6;
    logic [1:0]  err6;
    logic [0:0]  tflag6;
    logic [15:0] last6, max6;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    int lat_tab[4][8];
    int start_base[4];
    int start_tot[4] = '{default: 0};
    int rem[4]       = '{default: 0};

    always #5 clk = ~clk;

    vcnpu_run_sequencer dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .num_runs_i(num_runs), .ch_mask_i(ch_mask),
        .timeout_cycles_i(tmo), .npu_start_o(npu_start), .npu_done_i(npu_done),
        .busy_o(busy), .all_done_o(all_done), .pass_o(pass), .error_count_o(err),
        .timeout_flag_o(tflag), .last_cycles_o(last), .max_cycles_o(maxc)
    );

    vcnpu_run_sequencer #(.NUM_CH(1), .CNT_W(16), .RUNS_W(8), .ERR_W(2)) dut6 (
        .clk_i(clk), .rst_i(rst), .go_i(go6), .num_runs_i(runs6), .ch_mask_i(mask6),
        .timeout_cycles_i(tmo6), .npu_start_o(start6), .npu_done_i(done6),
        .busy_o(busy6), .all_done_o(all_done6), .pass_o(pass6), .error_count_o(err6),
        .timeout_flag_o(tflag6), .last_cycles_o(last6), .max_cycles_o(max6)
    );

    // NPU model: done is sampled on the lat-th rising edge after the LAUNCH edge; lat 0 = never
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (npu_start[i]) begin
                int idx;
                idx = start_tot[i] - start_base[i];
                rem[i] = (idx >= 0 && idx < 8) ? lat_tab[i][idx] : 0;
                start_tot[i] = start_tot[i] + 1;
                npu_done[i] = 1'b0;
            end else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                npu_done[i] = (rem[i] == 0);
            end else begin
                npu_done[i] = 1'b0;
            end
        end
    end

    function automatic logic [63:0] mx(input logic [63:0] v);
        return STATS_ON ? v : 64'd0;
    endfunction

    task automatic set_lat(input int ch, input int a, input int b, input int c);
        for (int k = 0; k < 8; k++) lat_tab[ch][k] = 0;
        lat_tab[ch][0] = a;
        lat_tab[ch][1] = b;
        lat_tab[ch][2] = c;
    endtask

    // Drive go for one cycle; returns at the negedge after the accepting edge
    task automatic pulse_go(input logic [7:0] r, input logic [3:0] m, input logic [15:0] t,
                            input bit immediate);
        if (!immediate) @(negedge clk);
        for (int i = 0; i < 4; i++) start_base[i] = start_tot[i];
        num_runs = r;
        ch_mask  = m;
        tmo      = t;
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (all_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (all_done !== 1'b0) $display("FAIL reset_all_done got %b want 0", all_done); else n_pass++;
        n_checks++; if (npu_start !== 4'h0) $display("FAIL reset_start got %h want 0", npu_start); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else n_pass++;
        n_checks++; if (err !== 8'd0) $display("FAIL reset_err got %0d want 0", err); else n_pass++;
        n_checks++; if (last !== 64'd0) $display("FAIL reset_last got %h want 0", last); else n_pass++;
        n_checks++; if (maxc !== 64'd0) $display("FAIL reset_max got %h want 0", maxc); else n_pass++;
    endtask

    // Pops the expected entry for the sequence that just ended and compares it
    task automatic test_sequence(input string nm, input logic [7:0] r, input logic [3:0] m,
                                 input logic [15:0] t, input exp_t e, input bit immediate);
        bit seen;
        exp_t x;
        sb.push_back(e);
        pulse_go(r, m, t, immediate);
        n_checks++; if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", nm, busy); else n_pass++;
        wait_done(3000, seen);
        n_checks++;
        if (!seen) begin
            $display("FAIL %s_done got no all_done want all_done", nm);
            return;
        end
        n_pass++;
        x = sb.pop_front();
        n_checks++; if (pass !== x.pass) $display("FAIL %s_pass got %b want %b", nm, pass, x.pass); else n_pass++;
        n_checks++; if (err !== x.err) $display("FAIL %s_err got %0d want %0d", nm, err, x.err); else n_pass++;
        n_checks++; if (tflag !== x.tflag) $display("FAIL %s_tflag got %b want %b", nm, tflag, x.tflag); else n_pass++;
        n_checks++; if (last !== x.last) $display("FAIL %s_last got %h want %h", nm, last, x.last); else n_pass++;
        n_checks++; if (maxc !== x.maxc) $display("FAIL %s_max got %h want %h", nm, maxc, x.maxc); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL %s_busy_end got %b want 0", nm, busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            int want;
            want = x.mask[i] ? int'(x.starts) : 0;
            n_checks++;
            if (start_tot[i] - start_base[i] !== want)
                $display("FAIL %s_starts ch%0d got %0d want %0d", nm, i, start_tot[i] - start_base[i], want);
            else n_pass++;
        end
    endtask

    task automatic test_all_channels();
        for (int i = 0; i < 4; i++) set_lat(i, 37, 0, 0);
        test_sequence("t1", 8'd1, 4'hF, 16'd100,
            '{pass: 1'b1, err: 8'd0, tflag: 4'h0, last: {16'd37, 16'd37, 16'd37, 16'd37},
              maxc: mx({16'd37, 16'd37, 16'd37, 16'd37}), starts: 4'd1, mask: 4'hF}, 1'b0);
        @(negedge clk);
        n_checks++; if (all_done !== 1'b0) $display("FAIL t1_done_width got %b want 0", all_done); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL t1_pass_hold got %b want 1", pass); else n_pass++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) set_lat(i, 0, 0, 0);
        set_lat(0, 10, 0, 0);
        test_sequence("t2", 8'd1, 4'b0101, 16'd50,
            '{pass: 1'b0, err: 8'd1, tflag: 4'b0100, last: {16'd37, 16'd50, 16'd37, 16'd10},
              maxc: mx({16'd0, 16'd50, 16'd0, 16'd10}), starts: 4'd1, mask: 4'b0101}, 1'b0);
    endtask

    task automatic test_multi_run();
        for (int i = 0; i < 4; i++) set_lat(i, 0, 0, 0);
        set_lat(0, 12, 40, 25);
        test_sequence("t3", 8'd3, 4'b0001, 16'd100,
            '{pass: 1'b1, err: 8'd0, tflag: 4'h0, last: {16'd37, 16'd50, 16'd37, 16'd25},
              maxc: mx({16'd0, 16'd0, 16'd0, 16'd40}), starts: 4'd3, mask: 4'b0001}, 1'b0);
    endtask

    task automatic test_empty();
        logic [7:0] rr [2];
        logic [3:0] mm [2];
        exp_t x;
        rr[0] = 8'd0; mm[0] = 4'hF;
        rr[1] = 8'd2; mm[1] = 4'h0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{pass: 1'b1, err: 8'd0, tflag: 4'h0, last: {16'd37, 16'd50, 16'd37, 16'd25},
                           maxc: 64'd0, starts: 4'd0, mask: 4'h0});
            pulse_go(rr[k], mm[k], 16'd10, 1'b0);
            n_checks++; if (all_done !== 1'b0) $display("FAIL t4_early_done case%0d got %b want 0", k, all_done); else n_pass++;
            @(negedge clk);
            n_checks++; if (all_done !== 1'b1) $display("FAIL t4_done_at_2 case%0d got %b want 1", k, all_done); else n_pass++;
            x = sb.pop_front();
            n_checks++; if (pass !== x.pass) $display("FAIL t4_pass case%0d got %b want %b", k, pass, x.pass); else n_pass++;
            n_checks++; if (last !== x.last) $display("FAIL t4_last case%0d got %h want %h", k, last, x.last); else n_pass++;
            n_checks++; if (maxc !== x.maxc) $display("FAIL t4_max case%0d got %h want %h", k, maxc, x.maxc); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (start_tot[i] !== start_base[i])
                    $display("FAIL t4_starts case%0d ch%0d got %0d want 0", k, i, start_tot[i] - start_base[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) set_lat(i, 0, 0, 0);
        set_lat(0, 5, 0, 0);
        set_lat(1, 8, 0, 0);
        test_sequence("bb_a", 8'd1, 4'b0011, 16'd100,
            '{pass: 1'b1, err: 8'd0, tflag: 4'h0, last: {16'd37, 16'd50, 16'd8, 16'd5},
              maxc: mx({16'd0, 16'd0, 16'd8, 16'd5}), starts: 4'd1, mask: 4'b0011}, 1'b0);
        // Second go issued in the all_done cycle of the first sequence
        test_sequence("bb_b", 8'd1, 4'b1000, 16'd3,
            '{pass: 1'b0, err: 8'd1, tflag: 4'b1000, last: {16'd3, 16'd50, 16'd8, 16'd5},
              maxc: mx({16'd3, 16'd0, 16'd0, 16'd0}), starts: 4'd1, mask: 4'b1000}, 1'b1);
    endtask

    task automatic test_go_abort();
        bit seen_done;
        for (int i = 0; i < 4; i++) set_lat(i, 0, 0, 0);
        pulse_go(8'd1, 4'hF, 16'd1000, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL t5_busy got %b want 1", busy); else n_pass++;
        num_runs = 8'd2; ch_mask = 4'b0001; tmo = 16'd5; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (start_tot[i] - start_base[i] !== 1)
                $display("FAIL t5_ignored_go ch%0d starts got %0d want 1", i, start_tot[i] - start_base[i]);
            else n_pass++;
        end
        n_checks++; if (tflag !== 4'h0) $display("FAIL t5_tflag_wait got %b want 0", tflag); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL t5_rst_busy got %b want 0", busy); else n_pass++;
        n_checks++;
        if ({pass, err, tflag, npu_start, last, maxc} !== '0)
            $display("FAIL t5_rst_outputs got pass=%b err=%0d tflag=%b last=%h want all 0", pass, err, tflag, last);
        else n_pass++;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (all_done === 1'b1 || busy !== 1'b0 || npu_start !== 4'h0) seen_done = 1'b1;
        end
        n_checks++; if (seen_done) $display("FAIL t5_post_rst_quiet got activity want none"); else n_pass++;
    endtask

    task automatic test_saturate();
        bit seen;
        int starts;
        seen = 1'b0;
        starts = 0;
        @(negedge clk);
        runs6 = 8'd5;
        go6 = 1'b1;
        @(negedge clk);
        go6 = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            if (start6[0] === 1'b1) starts++;
            if (all_done6 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL t6_done got no all_done want all_done");
            return;
        end
        n_pass++;
        n_checks++; if (err6 !== 2'd3) $display("FAIL t6_err got %0d want 3", err6); else n_pass++;
        n_checks++; if (pass6 !== 1'b0) $display("FAIL t6_pass got %b want 0", pass6); else n_pass++;
        n_checks++; if (tflag6 !== 1'b1) $display("FAIL t6_tflag got %b want 1", tflag6); else n_pass++;
        n_checks++; if (last6 !== 16'd2000) $display("FAIL t6_last got %0d want 2000", last6); else n_pass++;
        n_checks++; if (starts !== 5) $display("FAIL t6_starts got %0d want 5", starts); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_base[i] = 0;
            for (int k = 0; k < 8; k++) lat_tab[i][k] = 0;
        end
        test_reset();
        test_all_channels();
        test_timeout();
        test_multi_run();
        test_empty();
        test_back_to_back();
        test_go_abort();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
